// File: rtl/phase2speed_pkg.sv
// Shared defaults and FSM state type for the phase-difference to speed converter.
package phase2speed_pkg;
    localparam int NCH_DEF   = 3;
    localparam int PW_DEF    = 19;
    localparam int SW_DEF    = 16;
    localparam int KW_DEF    = 16;
    localparam int KFRAC_DEF = 8;
    localparam int ACC_XTRA  = 15;  // headroom for 2^15 summed samples

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;
endpackage

// File: rtl/p2s_scale_sat.sv
// Combinational average, gain, fixed-point shift and saturation for one channel.
module p2s_scale_sat #(
    parameter int AW    = 34,
    parameter int KW    = 16,
    parameter int KFRAC = 8,
    parameter int SW    = 16
) (
    input  logic [AW-1:0] i_hold,
    input  logic [3:0]    i_n,
    input  logic [KW-1:0] i_k,
    output logic [SW-1:0] o_spd,
    output logic          o_ovf
);
    localparam int PRW = AW + KW + 1;

    logic signed [AW-1:0]  w_avg;
    logic signed [PRW-1:0] w_prod;
    logic signed [PRW-1:0] w_shf;
    logic        [SW:0]    w_sat;

    // Returns {clipped, value}; clean when all bits above the result sign agree.
    function automatic logic [SW:0] sat(input logic signed [PRW-1:0] v);
        logic [PRW-SW:0] top;
        top = v[PRW-1:SW-1];
        if ((&top) || (~|top))
            sat = {1'b0, v[SW-1:0]};
        else if (v[PRW-1])
            sat = {1'b1, 1'b1, {(SW-1){1'b0}}};
        else
            sat = {1'b1, 1'b0, {(SW-1){1'b1}}};
    endfunction

    assign w_avg  = $signed(i_hold) >>> i_n;
    assign w_prod = PRW'(w_avg) * PRW'($signed({1'b0, i_k}));
    assign w_shf  = w_prod >>> KFRAC;
    assign w_sat  = sat(w_shf);
    assign o_ovf  = w_sat[SW];
    assign o_spd  = w_sat[SW-1:0];
endmodule

// File: rtl/phase2speed_mc.sv
// Multi-channel block averager feeding one shared gain/saturation stage, channels serialized.
module phase2speed_mc
    import phase2speed_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int PW    = PW_DEF,
    parameter int SW    = SW_DEF,
    parameter int KW    = KW_DEF,
    parameter int KFRAC = KFRAC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_rdy,
    input  logic [3:0]       N,
    input  logic [NCH*PW-1:0] in_phasediff,
    input  logic [KW-1:0]    scale_k,
    output logic [NCH*SW-1:0] out_speed,
    output logic             speeden,
    output logic [NCH-1:0]   ovf,
    output logic             overrun
);
    localparam int AW = PW + ACC_XTRA;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic signed [AW-1:0] r_acc  [NCH];
    logic signed [AW-1:0] r_hold [NCH];
    logic signed [AW-1:0] w_sum  [NCH];
    logic [15:0]          r_cnt;
    logic [3:0]           r_nlat;
    logic [3:0]           r_nhold;
    logic [3:0]           w_n_eff;
    logic [16:0]          w_cmp;
    logic                 w_last;
    logic                 w_start;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_ch;
    logic [NCH*SW-1:0]    r_stage;
    logic [NCH-1:0]       r_stage_ovf;
    logic [NCH*SW-1:0]    w_stage_nxt;
    logic [NCH-1:0]       w_stage_ovf_nxt;
    logic [NCH*SW-1:0]    r_out;
    logic [NCH-1:0]       r_ovf;
    logic                 r_overrun;
    logic [SW-1:0]        w_spd;
    logic                 w_ovf;

    // N is taken from the port only on the first sample of a block.
    assign w_n_eff = (r_cnt == 16'd0) ? N : r_nlat;
    assign w_cmp   = (17'd1 << w_n_eff) - 17'd1;
    assign w_last  = data_rdy && ({1'b0, r_cnt} == w_cmp);
    assign w_start = w_last && (r_state == S_IDLE);

    always_comb begin
        for (int c = 0; c < NCH; c++)
            w_sum[c] = r_acc[c] + AW'($signed(in_phasediff[c*PW +: PW]));
    end

    // Stage 0: accumulate and capture completed blocks
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt     <= 16'd0;
            r_nlat    <= 4'd0;
            r_nhold   <= 4'd0;
            r_overrun <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                r_acc[c]  <= '0;
                r_hold[c] <= '0;
            end
        end else begin
            if (data_rdy) begin
                if (r_cnt == 16'd0)
                    r_nlat <= N;
                if (w_last) begin
                    r_cnt <= 16'd0;
                    for (int c = 0; c < NCH; c++) r_acc[c] <= '0;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                    for (int c = 0; c < NCH; c++) r_acc[c] <= w_sum[c];
                end
            end
            if (w_start) begin
                r_nhold <= w_n_eff;
                for (int c = 0; c < NCH; c++) r_hold[c] <= w_sum[c];
            end
            if (w_last && (r_state != S_IDLE))
                r_overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= (r_state == S_MUL) ? r_ch + CW'(1) : '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_MUL;
            S_MUL:   if (r_ch == CW'(NCH - 1)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    p2s_scale_sat #(
        .AW(AW), .KW(KW), .KFRAC(KFRAC), .SW(SW)
    ) u_scale (
        .i_hold(r_hold[r_ch]),
        .i_n   (r_nhold),
        .i_k   (scale_k),
        .o_spd (w_spd),
        .o_ovf (w_ovf)
    );

    always_comb begin
        w_stage_nxt                  = r_stage;
        w_stage_ovf_nxt              = r_stage_ovf;
        w_stage_nxt[r_ch*SW +: SW]   = w_spd;
        w_stage_ovf_nxt[r_ch]        = w_ovf;
    end

    // Stage 1: serial per-channel results, published together with the last one
    always_ff @(posedge clk) begin
        if (r_state == S_MUL) begin
            r_stage     <= w_stage_nxt;
            r_stage_ovf <= w_stage_ovf_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out <= '0;
            r_ovf <= '0;
        end else if ((r_state == S_MUL) && (r_ch == CW'(NCH - 1))) begin
            r_out <= w_stage_nxt;
            r_ovf <= w_stage_ovf_nxt;
        end
    end

    assign out_speed = r_out;
    assign ovf       = r_ovf;
    assign speeden   = (r_state == S_DONE);
    assign overrun   = r_overrun;
endmodule

// File: tb/tb_phase2speed_mc.sv
// Directed and randomized block tests for phase2speed_mc against an arithmetic reference model.
module tb_phase2speed_mc;
    localparam int NCH = 3;
    localparam int PW  = 19;
    localparam int SW  = 16;
    localparam int KW  = 16;
    localparam longint RMAX = 262143;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              data_rdy = 1'b0;
    logic [3:0]        N = 4'd0;
    logic [NCH*PW-1:0] in_phasediff = '0;
    logic [KW-1:0]     scale_k = '0;
    logic [NCH*SW-1:0] out_speed;
    logic              speeden;
    logic [NCH-1:0]    ovf;
    logic              overrun;

    int     total = 0;
    int     bad = 0;
    longint sum [NCH];
    longint smp [NCH];

    phase2speed_mc dut (
        .clk(clk), .reset(reset), .data_rdy(data_rdy), .N(N),
        .in_phasediff(in_phasediff), .scale_k(scale_k),
        .out_speed(out_speed), .speeden(speeden), .ovf(ovf), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sums();
        for (int c = 0; c < NCH; c++) sum[c] = 0;
    endtask

    task automatic send();
        for (int c = 0; c < NCH; c++) begin
            in_phasediff[c*PW +: PW] = PW'(smp[c]);
            sum[c] += smp[c];
        end
        data_rdy = 1'b1;
        tick();
        data_rdy = 1'b0;
    endtask

    function automatic longint floordiv(input longint a, input longint d);
        longint q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model(input longint s, input int n, input int k,
                         output longint spd, output longint o);
        longint avg, p;
        avg = floordiv(s, longint'(1) << n);
        p   = floordiv(avg * k, 256);
        o   = 0;
        spd = p;
        if (p > 32767)  begin spd = 32767;  o = 1; end
        if (p < -32768) begin spd = -32768; o = 1; end
    endtask

    task automatic rand_smp();
        for (int c = 0; c < NCH; c++)
            smp[c] = longint'($urandom_range(2 * RMAX)) - RMAX;
    endtask

    // Called right after the block-completing sample was clocked in.
    task automatic expect_result(input string tag, input int n, input int k, input int exp_lat);
        int lat;
        longint e, o;
        lat = 0;
        while (!speeden && lat < 20) begin
            tick();
            lat++;
        end
        chk($sformatf("%s_lat", tag), lat, exp_lat);
        for (int c = 0; c < NCH; c++) begin
            model(sum[c], n, k, e, o);
            chk($sformatf("%s_spd%0d", tag, c), longint'($signed(out_speed[c*SW +: SW])), e);
            chk($sformatf("%s_ovf%0d", tag, c), longint'(ovf[c]), o);
        end
        tick();
        chk($sformatf("%s_pulse", tag), longint'(speeden), 0);
        clear_sums();
    endtask

    task automatic quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (speeden) seen = 1;
            tick();
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        longint saved [NCH];
        int n, k;
        clear_sums();

        // reset state
        repeat (3) tick();
        chk("rst_spd", longint'(out_speed), 0);
        chk("rst_ovf", longint'(ovf), 0);
        chk("rst_en", longint'(speeden), 0);
        chk("rst_ovr", longint'(overrun), 0);
        reset = 1'b1;
        tick();

        // 256-sample average with unity gain
        N = 4'd8; scale_k = 16'd256;
        smp[0] = 1000; smp[1] = -1000; smp[2] = 0;
        repeat (256) send();
        expect_result("avg256", 8, 256, 3);
        chk("avg256_c0", longint'($signed(out_speed[0 +: SW])), 1000);
        chk("avg256_c1", longint'($signed(out_speed[SW +: SW])), -1000);
        chk("avg256_c2", longint'($signed(out_speed[2*SW +: SW])), 0);

        // floor rounding and fractional gain
        N = 4'd1;
        smp[1] = 0; smp[2] = 0;
        smp[0] = -3; send(); smp[0] = -4; send();
        expect_result("floor", 1, 256, 3);
        chk("floor_c0", longint'($signed(out_speed[0 +: SW])), -4);
        scale_k = 16'd384;
        smp[0] = 10; send(); send();
        expect_result("gain", 1, 384, 3);
        chk("gain_c0", longint'($signed(out_speed[0 +: SW])), 15);
        quiet("hold_quiet", 3);
        chk("hold_c0", longint'($signed(out_speed[0 +: SW])), 15);

        // saturation both ways
        N = 4'd0; scale_k = 16'd256;
        smp[0] = 0; smp[1] = 200000; send();
        expect_result("satp", 0, 256, 3);
        chk("satp_ovf", longint'(ovf), 2);
        smp[1] = -200000; send();
        expect_result("satn", 0, 256, 3);
        chk("satn_c1", longint'($signed(out_speed[SW +: SW])), -32768);
        chk("ovr_clear", longint'(overrun), 0);

        // N change mid-block takes effect on the next block
        N = 4'd4; scale_k = 16'd256;
        for (int i = 0; i < 5; i++) begin rand_smp(); send(); end
        N = 4'd2;
        for (int i = 0; i < 10; i++) begin rand_smp(); send(); end
        quiet("nchg_early", 5);
        rand_smp(); send();
        expect_result("nchg16", 4, 256, 3);
        for (int i = 0; i < 3; i++) begin rand_smp(); send(); end
        quiet("nchg4_early", 5);
        rand_smp(); send();
        expect_result("nchg4", 2, 256, 3);

        // randomized blocks with idle gaps
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(0, 4);
            k = (it % 2 == 1) ? $urandom_range(0, 1023) : $urandom_range(0, 65535);
            N = 4'(n); scale_k = KW'(k);
            for (int s = 0; s < (1 << n); s++) begin
                rand_smp();
                send();
                if (s != (1 << n) - 1) repeat ($urandom_range(0, 2)) tick();
            end
            expect_result($sformatf("rnd%0d", it), n, k, 3);
        end

        // back-to-back N=0 blocks: second overruns, first still converts
        N = 4'd0; scale_k = 16'd256;
        smp[0] = 1234; smp[1] = -77; smp[2] = 5; send();
        for (int c = 0; c < NCH; c++) saved[c] = sum[c];
        clear_sums();
        smp[0] = 9; smp[1] = 9; smp[2] = 9; send();
        chk("ovr_set", longint'(overrun), 1);
        for (int c = 0; c < NCH; c++) sum[c] = saved[c];
        expect_result("ovr_first", 0, 256, 2);
        quiet("ovr_nosecond", 6);

        // reset during conversion aborts it
        rand_smp(); send();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        quiet("abort_quiet", 8);
        chk("abort_spd", longint'(out_speed), 0);
        chk("abort_ovf", longint'(ovf), 0);
        chk("abort_ovr", longint'(overrun), 0);
        clear_sums();
        N = 4'd2; scale_k = 16'd300;
        for (int i = 0; i < 4; i++) begin rand_smp(); send(); end
        expect_result("post_rst", 2, 300, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
